// File: rtl/perceptron_trainer.sv
// perceptron_trainer: online training engine for one 8-input perceptron.
// It evaluates a labelled sample against its own weights and applies the
// perceptron learning rule. The MAC and the weight update are both bit-serial,
// with one input processed per cycle.
module perceptron_trainer #(
    parameter logic [7:0]  W_INIT = 8'd1,
    parameter logic [10:0] THRESH = 11'd2,
    parameter logic [7:0]  LR     = 8'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  x_in,
    input  logic        target_in,
    input  logic        train_en,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        res_valid,
    output logic        y_out,
    output logic        err_out,
    output logic [63:0] weights_out,
    output logic [7:0]  err_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        EVAL,
        UPDATE,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [7:0]  w [8];
    logic [10:0] sum;
    logic [2:0]  idx;
    logic [7:0]  x_lat;
    logic        target_lat;
    logic        train_lat;

    logic [7:0]  cur_w;
    logic [8:0]  inc_w;
    logic [8:0]  dec_w;
    logic [7:0]  upd_w;
    logic        y_now;
    logic        err_now;

    // Activation decision and saturating weight step for the weight selected by idx.
    // The ninth bit of the step catches a carry past 255 or a borrow below 0.
    always_comb begin
        cur_w   = w[idx];
        y_now   = (sum >= THRESH);
        err_now = (y_now != target_lat);
        inc_w   = {1'b0, cur_w} + {1'b0, LR};
        dec_w   = {1'b0, cur_w} - {1'b0, LR};
        if (target_lat) begin
            upd_w = inc_w[8] ? 8'hFF : inc_w[7:0];
        end else begin
            upd_w = dec_w[8] ? 8'h00 : dec_w[7:0];
        end
    end

    // State register; reset aborts whatever sample is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept, accumulate, evaluate, optional update, report.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = ACCUM;
            ACCUM:   if (idx == 3'd7) state_next = EVAL;
            EVAL:    state_next = (err_now && train_lat) ? UPDATE : DONE;
            UPDATE:  if (idx == 3'd7) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: sample latch, serial MAC, result registers, error counter and weights.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                w[i] <= W_INIT;
            end
            sum        <= '0;
            idx        <= '0;
            x_lat      <= '0;
            target_lat <= 1'b0;
            train_lat  <= 1'b0;
            y_out      <= 1'b0;
            err_out    <= 1'b0;
            err_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_lat      <= x_in;
                        target_lat <= target_in;
                        train_lat  <= train_en;
                        sum        <= '0;
                        idx        <= '0;
                    end
                end
                ACCUM: begin
                    if (x_lat[idx]) begin
                        sum <= sum + {3'b000, cur_w};
                    end
                    idx <= idx + 3'd1;
                end
                EVAL: begin
                    y_out   <= y_now;
                    err_out <= err_now;
                    idx     <= '0;
                    if (err_now && (err_cnt != 8'hFF)) begin
                        err_cnt <= err_cnt + 8'd1;
                    end
                end
                UPDATE: begin
                    if (x_lat[idx]) begin
                        w[idx] <= upd_w;
                    end
                    idx <= idx + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Flat export of the live weight registers, w7 in the top byte.
    always_comb begin
        weights_out = '0;
        for (int i = 0; i < 8; i++) begin
            weights_out[i*8 +: 8] = w[i];
        end
    end

    assign in_ready  = (state == IDLE);
    assign res_valid = (state == DONE);

endmodule

// File: doc/perceptron_trainer.md
Name: perceptron_trainer

Overview:
Online training engine for one 8-input perceptron of the neural-network tile. Runs the backward direction of the forward perceptron/activation path: it takes a labelled sample, evaluates it against its own weight registers and applies the perceptron learning rule. The trained weights are exported flat so they can replace the hard-wired constants feeding the forward perceptrons. The MAC and the update are both bit-serial, one input per cycle, to keep area small.

Parameters:
W_INIT, 8'd1, reset value of every weight w0..w7
THRESH, 11'd2, activation threshold; y = (sum >= THRESH)
LR, 8'd1, learning-rate step added to or subtracted from a weight

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset
x_in  input  8  sample input bits; bit i gates weight wi
target_in  input  1  desired activation for the sample
train_en  input  1  1 = apply updates on error, 0 = inference/evaluate only
in_valid  input  1  sample offered
in_ready  output  1  block can accept a sample; high only in IDLE
res_valid  output  1  one-cycle pulse, result fields valid
y_out  output  1  computed activation of the last sample
err_out  output  1  y_out != target of the last sample
weights_out  output  64  {w7,...,w0}, 8 bits each, unsigned, live register values
err_cnt  output  8  number of errored samples since reset, saturates at 255

Interface decision: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset: state=IDLE, all wi=W_INIT, sum=0, idx=0, y_out=0, err_out=0, res_valid=0, err_cnt=0. in_ready=1 once reset deasserts.
- Handshake: a sample is accepted on a rising edge with in_valid & in_ready. x_in, target_in and train_en are latched, sum is cleared, idx=0, and the state moves to ACCUM. in_valid while busy is ignored, with no queueing.
- ACCUM (8 cycles, idx 0..7): sum += x[idx] ? {3'b0,w[idx]} : 0. sum is 11 bits and cannot overflow (max 8*255=2040). After idx=7 the state moves to EVAL.
- EVAL (1 cycle): y_out <= (sum >= THRESH); err_out <= y != target.
  - If err and latched train_en: err_cnt++ (saturating), idx=0, go to UPDATE.
  - If err and !train_en: err_cnt++ (saturating), go to DONE.
  - Else: go to DONE.
- UPDATE (8 cycles, idx 0..7): if x[idx]=1, then target=1 gives w[idx] = min(w+LR, 255) and target=0 gives w[idx] = max(w-LR, 0). If x[idx]=0 the weight is unchanged. After idx=7 the state moves to DONE.
- DONE (1 cycle): res_valid=1 and state goes to IDLE. y_out and err_out hold until the next EVAL.
- Latency, counting from the accept edge to the edge where res_valid is high:
  - 10 cycles with no update.
  - 18 cycles when an update is applied.
  - Throughput is one sample per 11 or 19 cycles, because in_ready is low during DONE.
- Saturation arithmetic must be 9-bit internally: no wrap at 255 and no underflow below 0.
- weights_out updates within a sample as each weight is written. Consumers sample it only after res_valid.
- Reset mid-operation (any state) aborts immediately. All weights return to W_INIT, a partially applied update is discarded, and no res_valid is issued.
- err_cnt counts errors whether or not train_en is set.

Test Plan:
- Defaults, x=8'h00, t=0 → sum 0, y=0, err=0. res_valid 10 cycles after accept. weights_out=64'h0101010101010101, err_cnt=0.
- From reset, x=8'h03, t=0, train_en=1 → sum 2, y=1, err=1. res_valid at 18 cycles. w0=w1=0, others 1; err_cnt=1. Resubmitting the same sample gives y=0, err=0.
- From reset, x=8'h01, t=1 → sum 1, y=0, err=1, w0=2. Resubmitting gives sum 2, y=1, err=0, 10-cycle latency.
- THRESH=0, x=8'h01, t=0, three samples → w0 goes 1→0→0, no underflow, err=1 each time, err_cnt=3. Separately, W_INIT=8'd254, LR=8'd4, THRESH=11'd2047, x=8'h01, t=1 → w0=255, no wrap.
- train_en=0, x=8'hFF, t=0 → y=1, err=1, weights unchanged, latency 10, err_cnt=1. in_valid held high during busy is not accepted until in_ready returns.
- Assert rst in ACCUM idx=4, then separately in UPDATE idx=3 → weights_out back to all W_INIT, err_cnt=0, no res_valid, in_ready=1 after release.
